// File: rtl/ad9911_pkg.sv
// Shared constants for the AD9911 configuration sequencer: register
// addresses, fixed register contents, step counts and the sequencer
// state encoding.
package ad9911_pkg;

    // AD9911 register addresses
    localparam logic [7:0] ADDR_CSR   = 8'h00;
    localparam logic [7:0] ADDR_FR1   = 8'h01;
    localparam logic [7:0] ADDR_CFR   = 8'h03;
    localparam logic [7:0] ADDR_CTW0  = 8'h04;
    localparam logic [7:0] ADDR_CPOW0 = 8'h05;
    localparam logic [7:0] ADDR_ACR   = 8'h06;

    // Fixed register contents
    localparam logic [7:0]  CSR_VAL  = 8'h10;
    localparam logic [23:0] ACR_BASE = 24'h001000;

    // Step counts: full init writes six registers, update-only writes four
    localparam int              STEP_W     = 3;
    localparam int              FULL_STEPS = 6;
    localparam int              UPD_STEPS  = 4;
    localparam logic [STEP_W-1:0] FULL_LAST = STEP_W'(FULL_STEPS - 1);
    localparam logic [STEP_W-1:0] UPD_LAST  = STEP_W'(UPD_STEPS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        GAP   = 3'd3,
        NEXT  = 3'd4,
        FIN   = 3'd5,
        ERRS  = 3'd6
    } seq_state_t;

    // ACR word: amplitude-scale-enable base OR'd with the 10-bit amplitude
    function automatic logic [31:0] acr_word(input logic [9:0] amp);
        return {8'h00, ACR_BASE | {14'h0000, amp}};
    endfunction

endpackage

// File: rtl/ad9911_seq_rom.sv
// Step table for the AD9911 sequencer. Maps the current step index,
// the latched update-only flag and the latched tuning words to the
// register address and LSB-aligned data of that write. Purely
// combinational; bits above each register's width are always zero.
module ad9911_seq_rom
    import ad9911_pkg::*;
#(
    parameter logic [23:0] FR1_VAL = 24'hD00000,
    parameter logic [23:0] CFR_VAL = 24'h000300
) (
    input  logic [STEP_W-1:0] step,
    input  logic              upd_only,
    input  logic [31:0]       freq_word,
    input  logic [13:0]       phase_word,
    input  logic [9:0]        amp_word,
    output logic [7:0]        addr,
    output logic [31:0]       data
);

    // Step index to register address; update-only skips FR1 and CFR
    always_comb begin
        addr = ADDR_CSR;
        if (upd_only) begin
            case (step)
                3'd1:    addr = ADDR_CTW0;
                3'd2:    addr = ADDR_CPOW0;
                3'd3:    addr = ADDR_ACR;
                default: addr = ADDR_CSR;
            endcase
        end else begin
            case (step)
                3'd1:    addr = ADDR_FR1;
                3'd2:    addr = ADDR_CFR;
                3'd3:    addr = ADDR_CTW0;
                3'd4:    addr = ADDR_CPOW0;
                3'd5:    addr = ADDR_ACR;
                default: addr = ADDR_CSR;
            endcase
        end
    end

    // Register address to zero-extended register contents
    always_comb begin
        data = 32'h0000_0000;
        case (addr)
            ADDR_CSR:   data = {24'h000000, CSR_VAL};
            ADDR_FR1:   data = {8'h00, FR1_VAL};
            ADDR_CFR:   data = {8'h00, CFR_VAL};
            ADDR_CTW0:  data = freq_word;
            ADDR_CPOW0: data = {18'h00000, phase_word};
            ADDR_ACR:   data = acr_word(amp_word);
            default:    data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/ad9911_cfg_sequencer.sv
// AD9911 configuration sequencer. On START it latches the tuning words
// and walks a short list of register writes (full init or update-only),
// handing each one to an external SPI register writer with a one-cycle
// WR_TR strobe and waiting for that writer's WR_OVER handshake.
// RESET must be the same reset that drives the SPI writer so that no
// writer frame outlives a sequencer reset.
// Optional feature: define AD9911_SEQ_TIMEOUT_EN to bound every wait for
// WR_OVER to TIMEOUT_CYCLES cycles after WR_TR and report a miss on ERR.
module ad9911_cfg_sequencer
    import ad9911_pkg::*;
#(
    parameter logic [23:0] FR1_VAL        = 24'hD00000,
    parameter logic [23:0] CFR_VAL        = 24'h000300,
    parameter int          TIMEOUT_CYCLES = 1023
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        UPD_ONLY,
    input  logic [31:0] FREQ_WORD,
    input  logic [13:0] PHASE_WORD,
    input  logic [9:0]  AMP_WORD,
    output logic        WR_TR,
    output logic [7:0]  WR_ADDR,
    output logic [31:0] WR_DATA,
    input  logic        WR_OVER,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    // The timeout compare needs at least two cycles of headroom
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    seq_state_t        state;
    seq_state_t        state_next;
    logic [STEP_W-1:0] step;
    logic              upd_only_q;
    logic [31:0]       freq_q;
    logic [13:0]       phase_q;
    logic [9:0]        amp_q;
    logic [7:0]        rom_addr;
    logic [31:0]       rom_data;
    logic              last_step;

    assign last_step = (step == (upd_only_q ? UPD_LAST : FULL_LAST));

    ad9911_seq_rom #(
        .FR1_VAL (FR1_VAL),
        .CFR_VAL (CFR_VAL)
    ) u_rom (
        .step       (step),
        .upd_only   (upd_only_q),
        .freq_word  (freq_q),
        .phase_word (phase_q),
        .amp_word   (amp_q),
        .addr       (rom_addr),
        .data       (rom_data)
    );

`ifdef AD9911_SEQ_TIMEOUT_EN
    // The counter is 0 in the first WAIT cycle (one cycle after WR_TR);
    // leaving WAIT at TIMEOUT_CYCLES-2 puts ERRS exactly TIMEOUT_CYCLES
    // cycles after the strobe.
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    assign timeout_hit = (wait_cnt >= TO_LIMIT);

    // Wait counter: cleared while issuing, advances while waiting
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequence context: words latched at START and the step index
    always_ff @(posedge CLK) begin
        if (RESET) begin
            step       <= '0;
            upd_only_q <= 1'b0;
            freq_q     <= '0;
            phase_q    <= '0;
            amp_q      <= '0;
        end else if (state == IDLE && START) begin
            step       <= '0;
            upd_only_q <= UPD_ONLY;
            freq_q     <= FREQ_WORD;
            phase_q    <= PHASE_WORD;
            amp_q      <= AMP_WORD;
        end else if (state == NEXT && !last_step) begin
            step <= step + 1'b1;
        end
    end

    // Next-state logic and Moore outputs; address/data are driven from
    // the step table for the whole life of a write and zero otherwise
    always_comb begin
        state_next = state;
        WR_TR      = 1'b0;
        WR_ADDR    = 8'h00;
        WR_DATA    = 32'h0000_0000;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        ERR        = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                WR_TR      = 1'b1;
                WR_ADDR    = rom_addr;
                WR_DATA    = rom_data;
                BUSY       = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                WR_ADDR = rom_addr;
                WR_DATA = rom_data;
                BUSY    = 1'b1;
                if (WR_OVER) begin
                    state_next = GAP;
                end
`ifdef AD9911_SEQ_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next = ERRS;
                end
`endif
            end
            GAP: begin
                WR_ADDR = rom_addr;
                WR_DATA = rom_data;
                BUSY    = 1'b1;
                if (!WR_OVER) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                WR_ADDR    = rom_addr;
                WR_DATA    = rom_data;
                BUSY       = 1'b1;
                state_next = last_step ? FIN : ISSUE;
            end
            FIN: begin
                DONE       = 1'b1;
                state_next = IDLE;
            end
            ERRS: begin
`ifdef AD9911_SEQ_TIMEOUT_EN
                ERR = 1'b1;
`endif
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
